score_keeper: RTL and testbench



---
 rtl/score_pkg.sv | 30 +++
 rtl/bcd2_sat_counter.sv | 35 +++
 rtl/score_keeper.sv | 122 ++++++++++++
 tb/tb_score_keeper.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, winner codes
// and BCD widths used by the tally counters.
package score_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD2_W      = 2 * BCD_DIGIT_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAYING  = 2'd1,
    HOLDOFF  = 2'd2,
    FINISHED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_T1   = 2'b01,
    W_T2   = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  // Packed BCD orders the same way as binary, so a plain compare is enough.
  function automatic winner_t decide_winner(input logic [BCD2_W-1:0] g1,
                                            input logic [BCD2_W-1:0] g2);
    if (g1 > g2)      return W_T1;
    else if (g2 > g1) return W_T2;
    else              return W_DRAW;
  endfunction

endpackage

// File: rtl/bcd2_sat_counter.sv
// Two-digit BCD up-counter with synchronous reset that holds at a
// saturation value instead of wrapping.
module bcd2_sat_counter
  import score_pkg::*;
#(
  parameter logic [BCD2_W-1:0] SAT_VALUE = 8'h99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [BCD2_W-1:0] count
);

  logic [BCD_DIGIT_W-1:0] lo;
  logic [BCD_DIGIT_W-1:0] hi;
  logic                   at_limit;

  assign lo = count[BCD_DIGIT_W-1:0];
  assign hi = count[BCD2_W-1:BCD_DIGIT_W];
  // 99 is also a hard stop so a non-99 saturation value can never wrap the high digit.
  assign at_limit = (count == SAT_VALUE) || (count == 8'h99);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      if (lo == BCD_DIGIT_W'(9)) begin
        count <= {hi + BCD_DIGIT_W'(1), BCD_DIGIT_W'(0)};
      end else begin
        count <= {hi, lo + BCD_DIGIT_W'(1)};
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Goal tally keeper downstream of game_controller: edge-detects goal levels,
// applies a post-goal hold-off, keeps BCD tallies and latches the winner.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned       HOLDOFF_CYCLES = 50000000,
  parameter logic [BCD2_W-1:0] MAX_GOALS_BCD  = 8'h99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              team1_score,
  input  logic              team2_score,
  input  logic              game_on,
  input  logic [7:0]        time_left,
  output logic [BCD2_W-1:0] team1_goals,
  output logic [BCD2_W-1:0] team2_goals,
  output logic [1:0]        goal_pulse,
  output logic              holdoff,
  output logic              finished,
  output logic [1:0]        winner,
  output state_t            dbg_state
);

  localparam int              CNT_W    = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             prev1;
  logic             prev2;
  logic             rise1;
  logic             rise2;
  logic             time_up;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       accept;
  winner_t          winner_q;

  assign rise1     = team1_score & ~prev1;
  assign rise2     = team2_score & ~prev2;
  assign time_up   = (time_left == 8'd0);
  assign dbg_state = state;
  assign winner    = winner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (time_up)      next_state = FINISHED;
        else if (game_on) next_state = PLAYING;
      end
      PLAYING: begin
        if (time_up)            next_state = FINISHED;
        else if (rise1 | rise2) next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (time_up)          next_state = FINISHED;
        else if (cnt == '0)   next_state = PLAYING;
      end
      FINISHED: next_state = FINISHED;
      default:  next_state = IDLE;
    endcase
  end

  // Time running out in the same cycle as a goal wins: the goal is dropped.
  always_comb begin
    accept   = 2'b00;
    holdoff  = 1'b0;
    finished = 1'b0;
    case (state)
      PLAYING:  accept   = time_up ? 2'b00 : {rise2, rise1};
      HOLDOFF:  holdoff  = 1'b1;
      FINISHED: finished = 1'b1;
      default:  ;
    endcase
  end

  // Edge registers reset high so a goal level already present at release is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev1      <= 1'b1;
      prev2      <= 1'b1;
      cnt        <= '0;
      goal_pulse <= 2'b00;
      winner_q   <= W_NONE;
    end else begin
      prev1      <= team1_score;
      prev2      <= team2_score;
      goal_pulse <= accept;
      if (state == PLAYING && next_state == HOLDOFF) begin
        cnt <= CNT_LOAD;
      end else if (state == HOLDOFF && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (next_state == FINISHED && state != FINISHED) begin
        winner_q <= decide_winner(team1_goals, team2_goals);
      end
    end
  end

  bcd2_sat_counter #(.SAT_VALUE(MAX_GOALS_BCD)) u_team1_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept[0]),
    .count (team1_goals)
  );

  bcd2_sat_counter #(.SAT_VALUE(MAX_GOALS_BCD)) u_team2_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept[1]),
    .count (team2_goals)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: fixed vector table, directed corner sequences and
// random stimulus checked against an integer-level reference model.
module tb_score_keeper;
  import score_pkg::*;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       team1_score;
  logic       team2_score;
  logic       game_on;
  logic [7:0] time_left;
  logic [7:0] team1_goals;
  logic [7:0] team2_goals;
  logic [1:0] goal_pulse;
  logic       holdoff;
  logic       finished;
  logic [1:0] winner;
  state_t     dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: goals as integers, hold-off as cycles remaining.
  int         m_g1, m_g2, m_hold;
  bit         m_play, m_done, mp1, mp2;
  logic [1:0] m_pulse, m_win;

  typedef struct {
    logic       s1, s2, gon;
    logic [7:0] tl;
    logic [7:0] e1, e2;
    logic [1:0] ep;
    logic       eh, ef;
    logic [1:0] ew;
  } vec_t;

  vec_t tbl[6];

  score_keeper #(.HOLDOFF_CYCLES(HOLD), .MAX_GOALS_BCD(8'h99)) dut (
    .clk         (clk),
    .rst         (rst),
    .team1_score (team1_score),
    .team2_score (team2_score),
    .game_on     (game_on),
    .time_left   (time_left),
    .team1_goals (team1_goals),
    .team2_goals (team2_goals),
    .goal_pulse  (goal_pulse),
    .holdoff     (holdoff),
    .finished    (finished),
    .winner      (winner),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g1 = 0; m_g2 = 0; m_hold = 0;
    m_play = 0; m_done = 0; mp1 = 1; mp2 = 1;
    m_pulse = 2'b00; m_win = 2'b00;
  endtask

  task automatic model_step(input bit s1, input bit s2, input bit gon, input logic [7:0] tl);
    bit r1, r2;
    r1 = s1 && !mp1;
    r2 = s2 && !mp2;
    m_pulse = 2'b00;
    if (!m_done) begin
      if (tl == 0) begin
        m_done = 1;
        m_hold = 0;
        m_win  = (m_g1 > m_g2) ? 2'b01 : (m_g2 > m_g1) ? 2'b10 : 2'b11;
      end else if (!m_play) begin
        if (gon) m_play = 1;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (r1 || r2) begin
        if (r1 && m_g1 < 99) m_g1++;
        if (r2 && m_g2 < 99) m_g2++;
        m_pulse = {r2, r1};
        m_hold  = HOLD;
      end
    end
    mp1 = s1;
    mp2 = s2;
  endtask

  task automatic check_model();
    check("team1_goals", team1_goals, to_bcd(m_g1));
    check("team2_goals", team2_goals, to_bcd(m_g2));
    check("goal_pulse", goal_pulse, m_pulse);
    check("holdoff", holdoff, (m_hold > 0) && !m_done);
    check("finished", finished, m_done);
    check("winner", winner, m_win);
  endtask

  task automatic drive(input logic s1, input logic s2, input logic gon, input logic [7:0] tl);
    team1_score = s1;
    team2_score = s2;
    game_on     = gon;
    time_left   = tl;
  endtask

  task automatic step(input logic s1, input logic s2, input logic gon, input logic [7:0] tl);
    drive(s1, s2, gon, tl);
    model_step(s1, s2, gon, tl);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic s1, input logic s2);
    rst = 1'b1;
    drive(s1, s2, 1'b1, 8'd180);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_team1_goals", team1_goals, 8'h00);
    check("rst_team2_goals", team2_goals, 8'h00);
    check("rst_goal_pulse", goal_pulse, 2'b00);
    check("rst_holdoff", holdoff, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_winner", winner, 2'b00);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
  endtask

  task automatic goal_and_wait(input logic s1, input logic s2);
    step(s1, s2, 1'b1, 8'd180);
    repeat (HOLD) step(1'b0, 1'b0, 1'b1, 8'd180);
  endtask

  initial begin
    int pulses, hcycles;
    logic s1, s2;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'd180, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'd180, 8'h01, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'd180, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'd180, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h01, 8'h00, 2'b00, 1'b0, 1'b1, 2'b01};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'd0,   8'h01, 8'h00, 2'b00, 1'b0, 1'b1, 2'b01};

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].s1, tbl[i].s2, tbl[i].gon, tbl[i].tl);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_team1_goals", i), team1_goals, tbl[i].e1);
      check($sformatf("tbl%0d_team2_goals", i), team2_goals, tbl[i].e2);
      check($sformatf("tbl%0d_goal_pulse", i), goal_pulse, tbl[i].ep);
      check($sformatf("tbl%0d_holdoff", i), holdoff, tbl[i].eh);
      check($sformatf("tbl%0d_finished", i), finished, tbl[i].ef);
      check($sformatf("tbl%0d_winner", i), winner, tbl[i].ew);
    end

    // Goal level held for 20 cycles: one count, one pulse, full hold-off window.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd180);
    pulses = 0;
    hcycles = 0;
    repeat (20) begin
      step(1'b1, 1'b0, 1'b1, 8'd180);
      if (goal_pulse != 2'b00) pulses++;
      if (holdoff) hcycles++;
    end
    check("held_goal_tally", team1_goals, 8'h01);
    check("held_goal_pulses", 8'(pulses), 8'd1);
    check("held_goal_holdoff_len", 8'(hcycles), 8'(HOLD));

    // Simultaneous goals, then a team2 rise inside hold-off and one after it.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd180);
    step(1'b1, 1'b1, 1'b1, 8'd180);
    check("dual_pulse", goal_pulse, 2'b11);
    check("dual_t1", team1_goals, 8'h01);
    check("dual_t2", team2_goals, 8'h01);
    hcycles = 1;
    step(1'b0, 1'b0, 1'b1, 8'd180);
    if (holdoff) hcycles++;
    step(1'b0, 1'b1, 1'b1, 8'd180);
    if (holdoff) hcycles++;
    check("holdoff_rise_ignored", team2_goals, 8'h01);
    repeat (HOLD) begin
      step(1'b0, 1'b0, 1'b1, 8'd180);
      if (holdoff) hcycles++;
    end
    check("dual_holdoff_len", 8'(hcycles), 8'(HOLD));
    step(1'b0, 1'b1, 1'b1, 8'd180);
    check("after_holdoff_t2", team2_goals, 8'h02);

    // Saturation at 99.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd180);
    repeat (99) goal_and_wait(1'b1, 1'b0);
    check("reach_99", team1_goals, 8'h99);
    step(1'b1, 1'b0, 1'b1, 8'd180);
    check("sat_tally", team1_goals, 8'h99);
    check("sat_pulse", goal_pulse, 2'b01);
    check("sat_holdoff", holdoff, 1'b1);

    // 3-3 draw with time expiring inside hold-off.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd180);
    goal_and_wait(1'b1, 1'b1);
    goal_and_wait(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'd180);
    check("draw_in_holdoff", holdoff, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    check("draw_finished", finished, 1'b1);
    check("draw_winner", winner, 2'b11);
    step(1'b1, 1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b1, 1'b1, 8'd50);
    check("post_finish_t1", team1_goals, 8'h03);
    check("post_finish_t2", team2_goals, 8'h03);
    check("post_finish_winner", winner, 2'b11);

    // Goal held across reset release, then reset asserted in hold-off.
    do_reset(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'd180);
    step(1'b1, 1'b0, 1'b1, 8'd180);
    check("held_through_rst", team1_goals, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'd180);
    step(1'b1, 1'b0, 1'b1, 8'd180);
    check("rst_pre_holdoff", holdoff, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd180);
    do_reset(1'b0, 1'b0);

    // Random play against the reference model.
    do_reset(1'b0, 1'b0);
    s1 = 1'b0;
    s2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(s1, s2);
      end else begin
        if ($urandom_range(0, 5) == 0) s1 = ~s1;
        if ($urandom_range(0, 5) == 0) s2 = ~s2;
        step(s1, s2, $urandom_range(0, 9) != 0,
             ($urandom_range(0, 149) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
